prog_loader: RTL
================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h00000000, byte address of the first loaded word.
REQ-002 SHALL have parameter MAX_WORDS, default 256, largest accepted word count.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on posedge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port rx_valid  input  1  rx_byte holds a valid byte.
REQ-006 SHALL have port rx_byte  input  8  incoming byte stream.
REQ-007 SHALL have port rx_ready  output  1  loader accepts a byte this cycle.
REQ-008 SHALL have port mem_we  output  1  one-cycle write strobe into instruction memory.
REQ-009 SHALL have port mem_addr  output  32  write byte address.
REQ-010 SHALL have port mem_wdata  output  32  assembled instruction word.
REQ-011 SHALL have port cpu_rst  output  1  reset held on the CPU until the load completes.
REQ-012 SHALL have port done  output  1  load complete, CPU running.
REQ-013 SHALL have port err  output  1  load failed, sticky until rst.

Function
REQ-014 A byte SHALL be accepted only on a posedge where rx_valid and rx_ready are both 1.
REQ-015 The state machine SHALL have states LEN_HI, LEN_LO, LOAD, CHK, RUN and ERR.
REQ-016 LEN_HI SHALL accept count[15:8] and go to LEN_LO; LEN_LO SHALL accept count[7:0].
REQ-017 After LEN_LO: count > MAX_WORDS goes to ERR; count = 0 goes to CHK (RUN if no checksum); otherwise goes to LOAD.
REQ-018 LOAD SHALL assemble 4 bytes big-endian (first byte lands in [31:24]) per word.
REQ-019 On the cycle after the 4th byte of word k is accepted, mem_we SHALL be 1 for exactly one cycle, with mem_addr = BASE_ADDR + 4*k and mem_wdata equal to the assembled word.
REQ-020 rx_ready SHALL be 1 in LEN_HI, LEN_LO, LOAD and CHK, including mem_we cycles, and 0 in RUN and ERR.
REQ-021 After the last word's byte is accepted, the FSM SHALL go to CHK (or to RUN if no checksum); the final mem_we SHALL still be issued.
REQ-022 The word index SHALL be 16 bits wide and SHALL compare against count with no wrap; mem_addr arithmetic SHALL be 32-bit modulo.
REQ-023 In RUN, cpu_rst SHALL be 0 and done SHALL be 1, and the block SHALL stay there until rst, ignoring rx_valid.
REQ-024 In ERR, cpu_rst SHALL be 1, err SHALL be 1 and done SHALL be 0 until rst.
REQ-025 cpu_rst SHALL be 1 in every state except RUN, and SHALL fall on the first cycle of RUN, after the final mem_we.
REQ-026 Gaps in rx_valid SHALL stall the FSM with no state change and no spurious mem_we.

Reset
REQ-027 rst SHALL force, asynchronously: state=LEN_HI, byte/word counters=0, running XOR=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_rst=1, done=0, err=0.
REQ-028 rst asserted mid-load SHALL discard the partial word and issue no mem_we; loading SHALL restart at LEN_HI after release.

Configuration
REQ-029 Macro LOADER_CHKSUM_EN defined: CHK SHALL accept one byte; if it equals the XOR of all data bytes (0x00 for count=0), go to RUN, else go to ERR.
REQ-030 Macro LOADER_CHKSUM_EN undefined: CHK and the XOR register SHALL be absent, and the FSM SHALL go directly to RUN after the last word or after count=0.

Verification (LOADER_CHKSUM_EN defined, BASE_ADDR=0, MAX_WORDS=256)
REQ-031 Bytes 00,01,20,08,00,05,2D -> one mem_we with addr 0x0, data 0x20080005; next cycle cpu_rst=0 and done=1.
REQ-032 count=2 with random rx_valid gaps, words 0x8C010000 and 0x08000000 -> mem_we at addr 0x0 then 0x4, each exactly 1 cycle; no extra strobes.
REQ-033 Same stream as REQ-031 but checksum byte 0x2C -> err=1, cpu_rst stays 1, rx_ready=0.
REQ-034 Bytes 00,00,00 -> no mem_we; done=1 and cpu_rst=0.
REQ-035 Bytes 01,01 (count=257) -> err=1 the cycle after the 2nd byte; no mem_we.
REQ-036 rst pulsed after the 2nd data byte of word 0 -> all outputs return to reset values immediately; a full REQ-031 stream afterwards loads correctly.

Source files
------------

// File: rtl/prog_loader.sv
// Byte-stream program loader: length header, big-endian words into instruction memory, then
// releases the CPU. Define LOADER_CHKSUM_EN to require a trailing XOR checksum byte.
module prog_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_rst,
  output logic        done,
  output logic        err
);

`ifdef LOADER_CHKSUM_EN
  typedef enum logic [2:0] {StLenHi, StLenLo, StLoad, StChk, StRun, StErr} state_e;
`else
  typedef enum logic [2:0] {StLenHi, StLenLo, StLoad, StRun, StErr} state_e;
`endif

  state_e      state_q;
  logic [15:0] count_q;
  logic [15:0] word_idx_q;
  logic [1:0]  byte_cnt_q;
  logic [31:0] word_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        cpu_rst_q;
  logic        done_q;
  logic        err_q;
`ifdef LOADER_CHKSUM_EN
  logic [7:0]  xor_q;
`endif

  logic        accept;
  logic [15:0] len_full;
  logic [31:0] word_full;
  logic [16:0] idx_inc;
  logic        last_word;
  logic        too_long;

  assign rx_ready  = (state_q != StRun) && (state_q != StErr);
  assign accept    = rx_valid && rx_ready;
  assign len_full  = {count_q[15:8], rx_byte};
  assign word_full = {word_q[23:0], rx_byte};
  // 17-bit increment so the final index never wraps before the compare
  assign idx_inc   = {1'b0, word_idx_q} + 17'd1;
  assign last_word = (idx_inc == {1'b0, count_q});
  assign too_long  = 32'(len_full) > MAX_WORDS;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StLenHi;
      count_q     <= 16'd0;
      word_idx_q  <= 16'd0;
      byte_cnt_q  <= 2'd0;
      word_q      <= 32'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE_ADDR;
      mem_wdata_q <= 32'd0;
      cpu_rst_q   <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef LOADER_CHKSUM_EN
      xor_q       <= 8'd0;
`endif
    end else begin
      mem_we_q <= 1'b0;
      unique case (state_q)
        StLenHi: begin
          if (accept) begin
            count_q[15:8] <= rx_byte;
            state_q       <= StLenLo;
          end
        end
        StLenLo: begin
          if (accept) begin
            count_q    <= len_full;
            word_idx_q <= 16'd0;
            byte_cnt_q <= 2'd0;
            if (too_long) begin
              state_q <= StErr;
              err_q   <= 1'b1;
            end else if (len_full == 16'd0) begin
`ifdef LOADER_CHKSUM_EN
              state_q <= StChk;
`else
              state_q   <= StRun;
              done_q    <= 1'b1;
              cpu_rst_q <= 1'b0;
`endif
            end else begin
              state_q <= StLoad;
            end
          end
        end
        StLoad: begin
          if (accept) begin
            word_q     <= word_full;
            byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef LOADER_CHKSUM_EN
            xor_q      <= xor_q ^ rx_byte;
`endif
            if (byte_cnt_q == 2'd3) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= BASE_ADDR + {14'd0, word_idx_q, 2'b00};
              mem_wdata_q <= word_full;
              word_idx_q  <= idx_inc[15:0];
              if (last_word) begin
`ifdef LOADER_CHKSUM_EN
                state_q <= StChk;
`else
                // cpu_rst/done follow one cycle later, after the final strobe
                state_q <= StRun;
`endif
              end
            end
          end
        end
`ifdef LOADER_CHKSUM_EN
        StChk: begin
          if (accept) begin
            if (rx_byte == xor_q) begin
              state_q   <= StRun;
              done_q    <= 1'b1;
              cpu_rst_q <= 1'b0;
            end else begin
              state_q <= StErr;
              err_q   <= 1'b1;
            end
          end
        end
`endif
        StRun: begin
          done_q    <= 1'b1;
          cpu_rst_q <= 1'b0;
        end
        StErr: begin
          err_q     <= 1'b1;
          done_q    <= 1'b0;
          cpu_rst_q <= 1'b1;
        end
        default: state_q <= StLenHi;
      endcase
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rst   = cpu_rst_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
